// File: rtl/instruction_load_sequencer_pkg.sv
// Shared types and defaults for the instruction load sequencer.
package rv32i_load_pkg;

  // Load controller states.
  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    RELEASE,
    DONE,
    ERROR
  } load_state_t;

  // Default number of cycles a single write may wait for its acknowledge.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/instruction_load_sequencer_timeout.sv
// Per-word write-acknowledge timeout counter.
// Counts cycles while enabled; expired is high once the count reaches TIMEOUT_CYCLES-1.
module load_timeout_counter
  import rv32i_load_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign o_expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Clear wins over enable; the count saturates at the expiry value.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instruction_load_sequencer.sv
// Loads a program image into the fetch stage's instruction memory.
// Words arrive on a valid/ready source and are written one at a time; the
// fetch stage is held in reset until a load completes successfully.
module instruction_load_sequencer
  import rv32i_load_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned COUNT_W        = 9,
  parameter int unsigned ADDR_STEP      = 1,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [COUNT_W-1:0] i_word_count,
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_src_ready,
  output logic              o_fetch_rst,
  output logic              o_instruction_wr_en,
  output logic [ADDR_W-1:0] o_instruction_wr_addr,
  output logic [DATA_W-1:0] o_instruction_wr_data,
  input  logic              i_instruction_wr_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  load_state_t        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               src_ready_q, src_ready_d;
  logic               fetch_rst_q, fetch_rst_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  load_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (timer_clear),
    .i_enable (timer_enable),
    .o_expired(timer_expired)
  );

  assign o_src_ready           = src_ready_q;
  assign o_fetch_rst           = fetch_rst_q;
  assign o_instruction_wr_en   = wr_en_q;
  assign o_instruction_wr_addr = wr_addr_q;
  assign o_instruction_wr_data = wr_data_q;
  assign o_busy                = busy_q;
  assign o_done                = done_q;
  assign o_error               = error_q;

  // Next-state and registered-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    src_ready_d  = src_ready_q;
    fetch_rst_d  = fetch_rst_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    timer_clear  = (state_q != WRITE);
    timer_enable = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          addr_d      = i_base_addr;
          remaining_d = i_word_count;
          error_d     = 1'b0;
          fetch_rst_d = 1'b1;
          busy_d      = 1'b1;
          if (i_word_count == '0) begin
            state_d = RELEASE;
          end else begin
            state_d     = ACCEPT;
            src_ready_d = 1'b1;
          end
        end
      end

      ACCEPT: begin
        if (i_src_valid && src_ready_q) begin
          wr_data_d   = i_src_data;
          wr_addr_d   = addr_q;
          wr_en_d     = 1'b1;
          src_ready_d = 1'b0;
          state_d     = WRITE;
        end
      end

      WRITE: begin
        if (i_instruction_wr_valid) begin
          wr_en_d     = 1'b0;
          remaining_d = remaining_q - COUNT_W'(1);
          addr_d      = addr_q + ADDR_W'(ADDR_STEP);
          if (remaining_q == COUNT_W'(1)) begin
            state_d = RELEASE;
          end else begin
            state_d     = ACCEPT;
            src_ready_d = 1'b1;
          end
        end else if (timer_expired) begin
          state_d = ERROR;
          wr_en_d = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          timer_enable = 1'b1;
        end
      end

      RELEASE: begin
        fetch_rst_d = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      src_ready_q <= 1'b0;
      fetch_rst_q <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      src_ready_q <= src_ready_d;
      fetch_rst_q <= fetch_rst_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: doc/instruction_load_sequencer.md
Name: instruction_load_sequencer

Overview:
- Hardware controller that loads a program image into the RV32I fetch stage's instruction memory through its write port (wr_en / wr_addr / wr_data / wr_valid).
- Holds the fetch stage in reset for the whole load, then releases it.
- Takes words from a valid/ready source (boot ROM streamer, UART loader or bench driver).
- Sits between the loader source and RV32I_instruction_fetch_stage at the top level, replacing bench-side loader tasks.

Parameters:
- ADDR_W, 32, width of instruction write address.
- DATA_W, 32, width of instruction word.
- COUNT_W, 9, width of word-count input; 256 words representable.
- ADDR_STEP, 1, address increment per word (word-addressed memory).
- TIMEOUT_CYCLES, 16, maximum cycles to wait for i_instruction_wr_valid per word.

Ports:
- i_clk  in  1  single clock for all logic.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- i_base_addr  in  ADDR_W  first write address; sampled on accepted i_start.
- i_word_count  in  COUNT_W  number of words to load; sampled on accepted i_start.
- i_src_valid  in  1  source word available.
- i_src_data  in  DATA_W  source word.
- o_src_ready  out  1  sequencer can accept a word.
- o_fetch_rst  out  1  reset to fetch stage (drives its i_rst).
- o_instruction_wr_en  out  1  write request to fetch stage.
- o_instruction_wr_addr  out  ADDR_W  write address.
- o_instruction_wr_data  out  DATA_W  write data.
- i_instruction_wr_valid  in  1  write-accepted from fetch stage.
- o_busy  out  1  load in progress.
- o_done  out  1  one-cycle pulse on successful completion.
- o_error  out  1  sticky timeout flag; cleared by accepted i_start or i_rst.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; o_fetch_rst=1; o_src_ready=0; wr_en=0; wr_addr=0; wr_data=0; o_busy=0; o_done=0; o_error=0.
- o_fetch_rst stays 1 from reset until the first successful load completes.
- States: IDLE, ACCEPT, WRITE, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR + i_start:
  - capture base into addr register and count into remaining; clear o_error; o_fetch_rst=1; o_busy=1.
  - if count==0, go to RELEASE (no writes); else go to ACCEPT.
- ACCEPT: o_src_ready=1. On i_src_valid&&o_src_ready:
  - latch i_src_data into wr_data; drive wr_addr=addr; wr_en=1; o_src_ready=0; clear timeout counter; go to WRITE.
- WRITE: hold wr_en, wr_addr and wr_data stable. On i_instruction_wr_valid:
  - wr_en=0 next cycle; remaining-=1; addr+=ADDR_STEP, modulo 2^ADDR_W (wrap silently).
  - if remaining was 1, go to RELEASE; else go to ACCEPT.
- Throughput: 2 cycles minimum per word (source valid and wr_valid immediate).
- Timeout in WRITE: counter increments each cycle without wr_valid. When it reaches TIMEOUT_CYCLES-1 with no wr_valid:
  - go to ERROR; wr_en=0; o_error=1; o_busy=0; o_fetch_rst stays 1.
- RELEASE: one cycle; o_fetch_rst=0 next cycle; o_done=1 for exactly one cycle; o_busy=0; then go to DONE.
- DONE: o_fetch_rst=0 and held.
- i_start while busy (ACCEPT/WRITE/RELEASE): ignored, no state change.
- i_start and i_src_valid in the same cycle from IDLE: start accepted; the source word is not consumed until the next cycle (o_src_ready is still 0).
- i_instruction_wr_valid outside WRITE: ignored.
- i_rst mid-load: return to reset values next edge. Partial writes are not rolled back; o_fetch_rst returns to 1.

Decomposition:
- Package rv32i_load_pkg: state enum load_state_t {IDLE, ACCEPT, WRITE, RELEASE, DONE, ERROR}; default TIMEOUT constant.
- One sub-module, load_timeout_counter: clear/enable inputs, expired output, width clog2(TIMEOUT_CYCLES).
- Everything else stays in one FSM plus its datapath registers.

Test Plan:
- Reset then idle 10 cycles -> o_fetch_rst=1, wr_en=0, o_busy=0, o_done=0 throughout.
- Start base=0, count=256, src always valid with data=index, memory model returns wr_valid 1 cycle after wr_en -> 256 writes, addr 0x00..0xFF with data==addr; o_done pulses once; o_fetch_rst falls the same cycle; readback of fetch results matches.
- Start base=0xFFFFFFFE, count=4 -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; completes normally.
- Start count=0 -> no wr_en ever; o_done pulse 2 cycles after start; o_fetch_rst falls.
- wr_valid withheld on word 3 -> ERROR after 16 cycles; o_error=1; wr_en=0; o_fetch_rst=1. A new start clears o_error and the load succeeds.
- Assert i_rst during word 100 of 256; also pulse i_start mid-load -> mid-load start ignored; i_rst restores all reset values next cycle; a fresh start from base=0 completes.
